// File: rtl/aes_key_sequencer.sv
// rtl/aes_key_sequencer.sv - stores an AES-128 round-key set and streams it in either order
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_valid/key_ready   load handshake for round_key_in (11 x 128-bit round keys)
//   start_valid/ready     stream request; start_decrypt selects reverse order
//   flush                 synchronous abort back to IDLE, store kept
//   rk_valid/rk_ready     output stream handshake carrying rk_out, rk_round, rk_last
//   loaded, busy          status: store holds a set, FSM is streaming
module aes_key_sequencer #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [NR:0][127:0]   round_key_in,
  input  logic                 start_valid,
  input  logic                 start_decrypt,
  output logic                 start_ready,
  input  logic                 flush,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [127:0]         rk_out,
  output logic [3:0]           rk_round,
  output logic                 rk_last,
  output logic                 loaded,
  output logic                 busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [3:0] LAST_CNT = 4'(NR);

  state_t              state, state_next;
  logic [NR:0][127:0]  store;
  logic [3:0]          cnt;
  logic                dir;
  logic [3:0]          cnt_nx;
  logic [3:0]          round_nx;
  logic                dir_nx;
  logic                key_fire, start_fire, beat_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    key_ready   = 1'b0;
    start_ready = 1'b0;
    case (state)
      IDLE: begin
        key_ready   = !flush;
        // A key load in the same cycle would change the set under the stream.
        start_ready = loaded && !key_valid && !flush;
        if (start_valid && start_ready) state_next = STREAM;
      end
      STREAM: begin
        if (rk_valid && rk_ready && rk_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  assign busy       = (state == STREAM);
  assign key_fire   = key_valid && key_ready;
  assign start_fire = start_valid && start_ready;
  assign beat_fire  = busy && rk_valid && rk_ready && !flush;

  // Next beat index: 0 on start, otherwise saturating increment (never wraps).
  assign cnt_nx   = start_fire ? 4'd0 : ((cnt == LAST_CNT) ? cnt : cnt + 4'd1);
  assign dir_nx   = start_fire ? start_decrypt : dir;
  assign round_nx = dir_nx ? (LAST_CNT - cnt_nx) : cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store    <= '0;
      loaded   <= 1'b0;
      cnt      <= 4'd0;
      dir      <= 1'b0;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_round <= 4'd0;
      rk_last  <= 1'b0;
    end else begin
      if (key_fire) begin
        store  <= round_key_in;
        loaded <= 1'b1;
      end
      if (flush) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end else if (start_fire) begin
        dir      <= start_decrypt;
        cnt      <= cnt_nx;
        rk_valid <= 1'b1;
        rk_round <= round_nx;
        rk_out   <= store[round_nx];
        rk_last  <= 1'b0;
      end else if (beat_fire) begin
        if (rk_last) begin
          rk_valid <= 1'b0;
          rk_last  <= 1'b0;
        end else begin
          cnt      <= cnt_nx;
          rk_round <= round_nx;
          rk_out   <= store[round_nx];
          rk_last  <= (cnt_nx == LAST_CNT);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sequencer.sv
// tb/tb_aes_key_sequencer.sv - scoreboard bench for aes_key_sequencer
module tb_aes_key_sequencer;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                key_valid = 1'b0;
  logic                key_ready;
  logic [10:0][127:0]  round_key_in = '0;
  logic                start_valid = 1'b0;
  logic                start_decrypt = 1'b0;
  logic                start_ready;
  logic                flush = 1'b0;
  logic                rk_valid;
  logic                rk_ready = 1'b0;
  logic [127:0]        rk_out;
  logic [3:0]          rk_round;
  logic                rk_last;
  logic                loaded;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [10:0][127:0]  set_a, set_b, set_c;
  logic [132:0]        exp_q[$];

  aes_key_sequencer #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .round_key_in(round_key_in),
    .start_valid(start_valid), .start_decrypt(start_decrypt), .start_ready(start_ready),
    .flush(flush),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_round(rk_round), .rk_last(rk_last),
    .loaded(loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic push_expect(input logic dec, input logic [10:0][127:0] s);
    for (int i = 0; i <= 10; i++) begin
      logic [3:0] r;
      r = dec ? 4'(10 - i) : 4'(i);
      exp_q.push_back({r, (i == 10), s[r]});
    end
  endtask

  task automatic load_keys(input logic [10:0][127:0] s);
    key_valid = 1'b1;
    round_key_in = s;
    #1;
    n_cmp++;
    if (key_ready !== 1'b1) begin
      n_err++; $display("FAIL load_key_ready got=%b exp=1", key_ready);
    end
    @(posedge clk); @(negedge clk);
    key_valid = 1'b0;
    round_key_in = '0;
    n_cmp++;
    if (loaded !== 1'b1) begin
      n_err++; $display("FAIL loaded_after_load got=%b exp=1", loaded);
    end
  endtask

  task automatic do_start(input logic dec, input logic [10:0][127:0] s);
    start_valid = 1'b1;
    start_decrypt = dec;
    #1;
    n_cmp++;
    if (start_ready !== 1'b1) begin
      n_err++; $display("FAIL start_ready got=%b exp=1", start_ready);
    end
    push_expect(dec, s);
    @(posedge clk); @(negedge clk);
    start_valid = 1'b0;
    start_decrypt = 1'b0;
    n_cmp++;
    if (rk_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL first_beat_latency valid=%b busy=%b exp=1,1", rk_valid, busy);
    end
  endtask

  // abort_kind: 0 none, 1 flush at handshake abort_at, 2 reset at handshake abort_at
  task automatic collect(input int stall_pct, input int abort_kind, input int abort_at);
    int hs = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic done = 1'b0;
    logic [132:0] held = '0;
    logic [132:0] got, e;
    forever begin
      got = {rk_round, rk_last, rk_out};
      if (stalled) begin
        n_cmp++;
        if (rk_valid !== 1'b1 || got !== held) begin
          n_err++; $display("FAIL stall_hold got=%h exp=%h valid=%b", got, held, rk_valid);
        end
      end
      if (abort_kind == 1 && hs == abort_at) begin
        flush = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        rk_ready = 1'b0;
        #1;
        n_cmp++;
        if ({rk_valid, busy, loaded, key_ready} !== 4'b0011) begin
          n_err++; $display("FAIL flush_state got=%b exp=0011", {rk_valid, busy, loaded, key_ready});
        end
        exp_q.delete();
        return;
      end
      if (abort_kind == 2 && hs == abort_at) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rk_valid, rk_last, rk_round, rk_out, loaded, busy} !== '0) begin
          n_err++; $display("FAIL reset_async got=%b%b%h%h%b%b exp=0",
                            rk_valid, rk_last, rk_round, rk_out, loaded, busy);
        end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        rk_ready = 1'b0;
        #1;
        n_cmp++;
        if ({key_ready, start_ready} !== 2'b10) begin
          n_err++; $display("FAIL reset_release_ready got=%b exp=10", {key_ready, start_ready});
        end
        exp_q.delete();
        return;
      end
      rk_ready = ($urandom_range(99) >= stall_pct);
      if (rk_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_beat got=%h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (got !== e) begin
            n_err++; $display("FAIL beat%0d got=%h exp=%h", hs, got, e);
          end
        end
        hs++;
        if (rk_last) done = 1'b1;
      end
      stalled = rk_valid && !rk_ready;
      held = got;
      cyc++;
      @(posedge clk); @(negedge clk);
      if (done) begin
        rk_ready = 1'b0;
        #1;
        n_cmp++;
        if ({rk_valid, busy, hs == 11, exp_q.size() == 0} !== 4'b0011) begin
          n_err++; $display("FAIL stream_end valid=%b busy=%b hs=%0d left=%0d exp=0,0,11,0",
                            rk_valid, busy, hs, exp_q.size());
        end
        n_cmp++;
        if (loaded && start_ready !== 1'b1) begin
          n_err++; $display("FAIL restart_ready got=%b exp=1", start_ready);
        end
        if (stall_pct == 0) begin
          n_cmp++;
          if (cyc != 11) begin
            n_err++; $display("FAIL back_to_back cycles got=%0d exp=11", cyc);
          end
        end
        return;
      end
      if (cyc > 400) begin
        n_cmp++; n_err++;
        $display("FAIL stream_timeout hs=%0d exp=11", hs);
        rk_ready = 1'b0;
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rk_valid, rk_last, rk_round, rk_out, loaded, busy} !== '0) begin
      n_err++; $display("FAIL reset_outputs got=%b%b%h%h%b%b exp=0",
                        rk_valid, rk_last, rk_round, rk_out, loaded, busy);
    end
    rst_n = 1'b1;
    start_valid = 1'b1;
    #1;
    n_cmp++;
    if ({key_ready, start_ready} !== 2'b10) begin
      n_err++; $display("FAIL reset_ready got=%b exp=10", {key_ready, start_ready});
    end
    @(posedge clk); @(negedge clk);
    start_valid = 1'b0;
    n_cmp++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL start_without_keys valid=%b busy=%b exp=0,0", rk_valid, busy);
    end
  endtask

  task automatic test_encrypt;
    load_keys(set_a);
    do_start(1'b0, set_a);
    collect(0, 0, 0);
  endtask

  task automatic test_decrypt;
    do_start(1'b1, set_a);
    collect(0, 0, 0);
  endtask

  task automatic test_backpressure;
    load_keys(set_c);
    do_start(1'b0, set_c);
    collect(45, 0, 0);
    do_start(1'b1, set_c);
    collect(60, 0, 0);
  endtask

  task automatic test_flush;
    load_keys(set_a);
    do_start(1'b0, set_a);
    collect(0, 1, 4);
    do_start(1'b0, set_a);
    collect(20, 0, 0);
  endtask

  task automatic test_key_and_start;
    key_valid = 1'b1;
    round_key_in = set_b;
    start_valid = 1'b1;
    start_decrypt = 1'b0;
    #1;
    n_cmp++;
    if ({key_ready, start_ready} !== 2'b10) begin
      n_err++; $display("FAIL key_blocks_start got=%b exp=10", {key_ready, start_ready});
    end
    @(posedge clk); @(negedge clk);
    key_valid = 1'b0;
    round_key_in = set_a;
    n_cmp++;
    if (rk_valid !== 1'b0) begin
      n_err++; $display("FAIL start_taken_with_key got=%b exp=0", rk_valid);
    end
    do_start(1'b0, set_b);
    collect(0, 0, 0);
  endtask

  task automatic test_reset_mid_stream;
    do_start(1'b0, set_b);
    collect(0, 2, 2);
    start_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({rk_valid, start_ready, loaded} !== 3'b000) begin
        n_err++; $display("FAIL start_after_reset got=%b exp=000", {rk_valid, start_ready, loaded});
      end
    end
    start_valid = 1'b0;
    load_keys(set_c);
    do_start(1'b1, set_c);
    collect(30, 0, 0);
  endtask

  initial begin
    set_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    set_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    set_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    set_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    set_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    set_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    set_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    set_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    set_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    set_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    set_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i <= 10; i++) begin
      set_b[i] = {$urandom, $urandom, $urandom, $urandom};
      set_c[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_flush();
    test_key_and_start();
    test_reset_mid_stream();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
